// File: rtl/ddr_arb_pkg.sv
// Shared types for the two-requester Avalon-MM DDR arbiter: FSM states,
// requester id and the outstanding-read tag record.
package ddr_arb_pkg;

  // Width of the burstcount carried in a tag; the top's BURST_WIDTH defaults to this.
  localparam int TAG_BC_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  typedef struct packed {
    req_id_t             id;
    logic [TAG_BC_W-1:0] bc;
  } tag_t;

  // Avalon treats a burstcount of zero as a single beat.
  function automatic logic [TAG_BC_W-1:0] eff_burst(input logic [TAG_BC_W-1:0] bc);
    return (bc == '0) ? TAG_BC_W'(1) : bc;
  endfunction

endpackage

// File: rtl/ddr_arb_tag_fifo.sv
// Synchronous FIFO of outstanding read tags; head entry is visible combinationally.
module ddr_arb_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  tag_t          push_tag,
  input  logic          pop,
  output tag_t          head_tag,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  tag_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_tag;
  end

  assign head_tag = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/ddr_amm_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM DDR port between two requesters,
// granting whole read commands or whole write bursts and routing read data back by tag.
module ddr_amm_arbiter
  import ddr_arb_pkg::*;
#(
  parameter  int DDR_DATA_WIDTH = 64,
  parameter  int DDR_ADDR_WIDTH = 32,
  parameter  int BURST_WIDTH    = TAG_BC_W,
  parameter  int TAG_DEPTH      = 8,
  localparam int CNT_W          = $clog2(TAG_DEPTH) + 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      local_init_done,
  input  logic [DDR_ADDR_WIDTH-1:0] r0_addr,
  input  logic [DDR_DATA_WIDTH-1:0] r0_wdata,
  input  logic                      r0_ren,
  input  logic                      r0_wen,
  input  logic [BURST_WIDTH-1:0]    r0_burstcount,
  output logic                      r0_wait,
  output logic                      r0_rvalid,
  output logic [DDR_DATA_WIDTH-1:0] r0_rdata,
  input  logic [DDR_ADDR_WIDTH-1:0] r1_addr,
  input  logic [DDR_DATA_WIDTH-1:0] r1_wdata,
  input  logic                      r1_ren,
  input  logic                      r1_wen,
  input  logic [BURST_WIDTH-1:0]    r1_burstcount,
  output logic                      r1_wait,
  output logic                      r1_rvalid,
  output logic [DDR_DATA_WIDTH-1:0] r1_rdata,
  input  logic                      amm_wait,
  input  logic                      amm_rvalid,
  input  logic [DDR_DATA_WIDTH-1:0] amm_rdata,
  output logic [DDR_ADDR_WIDTH-1:0] amm_addr,
  output logic [DDR_DATA_WIDTH-1:0] amm_wdata,
  output logic                      amm_ren,
  output logic                      amm_wen,
  output logic [BURST_WIDTH-1:0]    amm_burstcount,
  output logic                      err_rvalid,
  output arb_state_e                dbg_state,
  output logic [CNT_W-1:0]          dbg_tag_count
);

  // Handshake: a command/beat transfers in a cycle where its ren/wen is high and
  // the matching wait is low; the side raising ren/wen holds everything until then.

  arb_state_e                state_q, state_d;
  req_id_t                   grant_q, grant_d;
  req_id_t                   last_winner_q, last_winner_d;
  logic                      first_q, first_d;
  logic [BURST_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
  logic [BURST_WIDTH-1:0]    beats_done_q, beats_done_d;
  logic                      err_q, err_d;

  req_id_t                   win;
  logic                      sel_wait, tag_push, tag_pop, tag_full, tag_empty;
  logic                      ret_hit, head_last;
  tag_t                      push_tag, head_tag;
  logic [DDR_ADDR_WIDTH-1:0] sel_addr;
  logic [DDR_DATA_WIDTH-1:0] sel_wdata;
  logic [BURST_WIDTH-1:0]    sel_bc;
  logic                      sel_ren, sel_wen;

  assign sel_addr  = grant_q ? r1_addr       : r0_addr;
  assign sel_wdata = grant_q ? r1_wdata      : r0_wdata;
  assign sel_bc    = grant_q ? r1_burstcount : r0_burstcount;
  assign sel_ren   = grant_q ? r1_ren        : r0_ren;
  assign sel_wen   = grant_q ? r1_wen        : r0_wen;
  assign push_tag  = '{id: grant_q, bc: sel_bc};

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_winner_d  = last_winner_q;
    first_d        = first_q;
    beat_cnt_d     = beat_cnt_q;
    win            = last_winner_q;
    sel_wait       = 1'b1;
    tag_push       = 1'b0;
    amm_addr       = '0;
    amm_wdata      = '0;
    amm_burstcount = '0;
    amm_ren        = 1'b0;
    amm_wen        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (local_init_done && (r0_ren || r0_wen || r1_ren || r1_wen)) begin
          if ((r0_ren || r0_wen) && (r1_ren || r1_wen)) win = ~last_winner_q;
          else                                           win = r1_ren || r1_wen;
          grant_d       = win;
          last_winner_d = win;
          first_d       = 1'b1;
          state_d       = (win ? r1_ren : r0_ren) ? ST_RD : ST_WR;
        end
      end
      ST_RD: begin
        amm_addr       = sel_addr;
        amm_wdata      = sel_wdata;
        amm_burstcount = sel_bc;
        amm_ren        = sel_ren & ~tag_full;
        sel_wait       = amm_wait | tag_full;
        if (sel_ren && !tag_full && !amm_wait) begin
          tag_push = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WR: begin
        amm_addr       = sel_addr;
        amm_wdata      = sel_wdata;
        amm_burstcount = sel_bc;
        amm_wen        = sel_wen;
        sel_wait       = amm_wait;
        // beat_cnt holds the beats still owed after the most recently accepted one.
        if (sel_wen && !amm_wait) begin
          if (first_q) begin
            first_d    = 1'b0;
            beat_cnt_d = sel_bc - 1'b1;
            if (sel_bc <= BURST_WIDTH'(1)) state_d = ST_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q - 1'b1;
            if (beat_cnt_q <= BURST_WIDTH'(1)) state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign r0_wait = (grant_q == 1'b0) ? sel_wait : 1'b1;
  assign r1_wait = (grant_q == 1'b1) ? sel_wait : 1'b1;

  always_comb begin
    ret_hit      = amm_rvalid && !tag_empty;
    head_last    = ((beats_done_q + 1'b1) == eff_burst(head_tag.bc));
    tag_pop      = ret_hit && head_last;
    beats_done_d = beats_done_q;
    if (ret_hit) beats_done_d = head_last ? '0 : beats_done_q + 1'b1;
    err_d        = err_q | (amm_rvalid & tag_empty);
  end

  assign r0_rvalid  = ret_hit && (head_tag.id == 1'b0);
  assign r1_rvalid  = ret_hit && (head_tag.id == 1'b1);
  assign r0_rdata   = amm_rdata;
  assign r1_rdata   = amm_rdata;
  assign err_rvalid = err_q;
  assign dbg_state  = state_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      grant_q       <= 1'b0;
      last_winner_q <= 1'b1;
      first_q       <= 1'b0;
      beat_cnt_q    <= '0;
      beats_done_q  <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_winner_q <= last_winner_d;
      first_q       <= first_d;
      beat_cnt_q    <= beat_cnt_d;
      beats_done_q  <= beats_done_d;
      err_q         <= err_d;
    end
  end

  ddr_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (tag_push),
    .push_tag (push_tag),
    .pop      (tag_pop),
    .head_tag (head_tag),
    .full     (tag_full),
    .empty    (tag_empty),
    .count    (dbg_tag_count)
  );

endmodule

// File: tb/tb_ddr_amm_arbiter.sv
// Bench for ddr_amm_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of requesters and controller.
module tb_ddr_amm_arbiter;
  import ddr_arb_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int BW = 6;
  localparam int TD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          local_init_done;
  logic [AW-1:0] r0_addr, r1_addr, amm_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, amm_rdata, amm_wdata;
  logic          r0_ren, r0_wen, r1_ren, r1_wen, r0_wait, r1_wait;
  logic          r0_rvalid, r1_rvalid;
  logic [BW-1:0] r0_burstcount, r1_burstcount, amm_burstcount;
  logic          amm_wait, amm_rvalid, amm_ren, amm_wen, err_rvalid;
  arb_state_e    dbg_state;
  logic [3:0]    dbg_tag_count;

  always #5 clk = ~clk;

  ddr_amm_arbiter #(.DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW), .BURST_WIDTH(BW), .TAG_DEPTH(TD)) dut (
    .CLK(clk), .RST(rst), .local_init_done(local_init_done),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_ren(r0_ren), .r0_wen(r0_wen),
    .r0_burstcount(r0_burstcount), .r0_wait(r0_wait), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_ren(r1_ren), .r1_wen(r1_wen),
    .r1_burstcount(r1_burstcount), .r1_wait(r1_wait), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .amm_wait(amm_wait), .amm_rvalid(amm_rvalid), .amm_rdata(amm_rdata),
    .amm_addr(amm_addr), .amm_wdata(amm_wdata), .amm_ren(amm_ren), .amm_wen(amm_wen),
    .amm_burstcount(amm_burstcount), .err_rvalid(err_rvalid),
    .dbg_state(dbg_state), .dbg_tag_count(dbg_tag_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard: owner id of every read beat still owed by the controller.
  logic [0:0] exp_q[$];

  // Requester model state for the randomized phase.
  logic          act[2];
  logic          is_rd[2];
  logic [BW-1:0] rbc[2];
  int            left[2];
  int            beat[2];
  int unsigned   seq[2];
  logic [AW-1:0] radr[2];
  logic          acc[2];

  int   k, wl, cyc, n0, n1, own;
  logic acc1, amm_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_addr = '0; r0_wdata = '0; r0_ren = 1'b0; r0_wen = 1'b0; r0_burstcount = '0;
    r1_addr = '0; r1_wdata = '0; r1_ren = 1'b0; r1_wen = 1'b0; r1_burstcount = '0;
    amm_wait = 1'b0; amm_rvalid = 1'b0; amm_rdata = '0;
  endtask

  function automatic logic [DW-1:0] wdata_of(input int n, input int unsigned s, input int b);
    return (64'(n) << 60) | (64'(s) << 16) | 64'(b);
  endfunction

  task automatic drive_reqs();
    r0_ren = act[0] && is_rd[0];  r0_wen = act[0] && !is_rd[0];
    r0_addr = radr[0];  r0_burstcount = rbc[0];  r0_wdata = wdata_of(0, seq[0], beat[0]);
    r1_ren = act[1] && is_rd[1];  r1_wen = act[1] && !is_rd[1];
    r1_addr = radr[1];  r1_burstcount = rbc[1];  r1_wdata = wdata_of(1, seq[1], beat[1]);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ren"},   amm_ren, 1'b0);
    check({tag, "_wen"},   amm_wen, 1'b0);
    check({tag, "_addr"},  amm_addr, '0);
    check({tag, "_wdata"}, amm_wdata, '0);
    check({tag, "_bc"},    amm_burstcount, '0);
    check({tag, "_w0"},    r0_wait, 1'b1);
    check({tag, "_w1"},    r1_wait, 1'b1);
    check({tag, "_err"},   err_rvalid, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    local_init_done = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    half();
    check_idle_outputs("reset");
    check("reset_rv0", r0_rvalid, 1'b0);
    check("reset_rv1", r1_rvalid, 1'b0);
    check("reset_state", dbg_state, ST_IDLE);
    tick();
    rst = 1'b0;

    // No grant before calibration completes.
    r0_ren = 1'b1; r0_burstcount = 6'd1;
    repeat (3) begin
      tick(); half();
      check("init_low_ren", amm_ren, 1'b0);
      check("init_low_wait", r0_wait, 1'b1);
    end
    tick();
    r0_ren = 1'b0; local_init_done = 1'b1;
    half(); tick();

    // Tied writes of two beats: r0 first, then r1, then r0 again on the next tie.
    r0_wen = 1'b1; r1_wen = 1'b1; r0_burstcount = 6'd2; r1_burstcount = 6'd2;
    r0_wdata = 64'hA0; r1_wdata = 64'hB0;
    half(); check("t2_idle_wen", amm_wen, 1'b0);
    tick(); half();
    check("t2_r0_first", amm_wdata, 64'hA0); check("t2_r0_wait", r0_wait, 1'b0);
    check("t2_r1_held", r1_wait, 1'b1);      check("t2_wen", amm_wen, 1'b1);
    tick(); r0_wdata = 64'hA1;
    half(); check("t2_r0_beat1", amm_wdata, 64'hA1);
    tick(); r0_wen = 1'b0;
    half(); check("t2_gap_idle", amm_wen, 1'b0); check("t2_gap_w1", r1_wait, 1'b1);
    tick(); half();
    check("t2_r1_beat0", amm_wdata, 64'hB0); check("t2_r1_wait", r1_wait, 1'b0);
    check("t2_r0_wait", r0_wait, 1'b1);
    tick(); r1_wdata = 64'hB1;
    half(); check("t2_r1_beat1", amm_wdata, 64'hB1);
    tick(); r1_wen = 1'b0;
    r0_wen = 1'b1; r1_wen = 1'b1; r0_burstcount = 6'd1; r1_burstcount = 6'd0;
    r0_wdata = 64'hA8; r1_wdata = 64'hB8;
    half(); tick(); half();
    check("t2_tie2_r0", amm_wdata, 64'hA8); check("t2_tie2_w0", r0_wait, 1'b0);
    tick(); r0_wen = 1'b0;
    half(); check("t2_bc1_single", amm_wen, 1'b0);
    tick(); half();
    check("t2_bc0_r1", amm_wdata, 64'hB8); check("t2_bc0_w1", r1_wait, 1'b0);
    tick(); r1_wen = 1'b0;
    half(); check("t2_bc0_single", amm_wen, 1'b0);
    tick();

    // r1 burst of 4 with three wait cycles on beat 2; r0 waits throughout.
    r1_wen = 1'b1; r1_burstcount = 6'd4; r1_wdata = 64'hC0;
    half(); check("t3_idle", amm_wen, 1'b0);
    tick();
    r0_wen = 1'b1; r0_burstcount = 6'd1; r0_wdata = 64'hD0;
    k = 0; wl = 0; cyc = 0;
    while (k < 4 && cyc < 20) begin
      amm_wait = (wl > 0);
      half();
      check("t3_r0_held", r0_wait, 1'b1);
      check("t3_wdata", amm_wdata, 64'hC0 + 64'(k));
      check("t3_r1_wait", r1_wait, amm_wait);
      acc1 = !r1_wait;
      tick(); cyc++;
      if (wl > 0) wl--;
      if (acc1) begin
        k++;
        r1_wdata = 64'hC0 + 64'(k);
        if (k == 1) wl = 3;
      end
    end
    check("t3_beats", 64'(k), 64'd4);
    check("t3_cycles", 64'(cyc), 64'd7);
    amm_wait = 1'b0;
    half(); check("t3_end_idle", amm_wen, 1'b0);
    tick(); half();
    check("t3_r0_granted", amm_wdata, 64'hD0); check("t3_r0_wait", r0_wait, 1'b0);
    check("t3_r1_wait_after", r1_wait, 1'b1);
    tick(); r0_wen = 1'b0; r1_wen = 1'b0;
    half(); tick();

    // r0 read of 4 beats at 0x100.
    r0_ren = 1'b1; r0_addr = 32'h100; r0_burstcount = 6'd4;
    half(); check("t1_idle_ren", amm_ren, 1'b0);
    tick(); half();
    check("t1_ren", amm_ren, 1'b1); check("t1_addr", amm_addr, 32'h100);
    check("t1_bc", amm_burstcount, 6'd4); check("t1_w0", r0_wait, 1'b0);
    check("t1_w1", r1_wait, 1'b1);
    tick(); r0_ren = 1'b0;
    half(); check("t1_one_cycle", amm_ren, 1'b0);
    tick();
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin
      amm_rvalid = 1'b1; amm_rdata = 64'hF00 + 64'(i);
      half();
      n0 += int'(r0_rvalid); n1 += int'(r1_rvalid);
      check("t1_rdata", r0_rdata, 64'hF00 + 64'(i));
      tick();
    end
    amm_rvalid = 1'b0;
    check("t1_r0_pulses", 64'(n0), 64'd4);
    check("t1_r1_pulses", 64'(n1), 64'd0);

    // Eight single-beat reads fill the tag FIFO; the ninth stalls.
    r0_ren = 1'b1; r0_burstcount = 6'd1;
    for (int i = 0; i < 8; i++) begin
      r0_addr = 32'h200 + 32'(i);
      half(); tick(); half();
      check("t4_issue", amm_ren, 1'b1); check("t4_addr", amm_addr, 32'h200 + 32'(i));
      tick();
    end
    r0_addr = 32'h208;
    half(); tick();
    for (int j = 0; j < 3; j++) begin
      half();
      check("t4_stall_ren", amm_ren, 1'b0); check("t4_stall_wait", r0_wait, 1'b1);
      check("t4_count", dbg_tag_count, 4'd8);
      tick();
    end
    amm_rvalid = 1'b1; amm_rdata = 64'h55;
    half();
    check("t4_pop_rv", r0_rvalid, 1'b1);
    check("t4_pop_still_ren", amm_ren, 1'b0); check("t4_pop_still_wait", r0_wait, 1'b1);
    tick(); amm_rvalid = 1'b0;
    half(); check("t4_release_ren", amm_ren, 1'b1); check("t4_release_wait", r0_wait, 1'b0);
    tick(); r0_ren = 1'b0;
    for (int i = 0; i < 8; i++) begin
      amm_rvalid = 1'b1;
      half(); check("t4_drain_rv0", r0_rvalid, 1'b1); check("t4_drain_rv1", r1_rvalid, 1'b0);
      tick();
    end
    amm_rvalid = 1'b0;

    // Interleaved reads: r0 burst 3 then r1 burst 2, returns delayed.
    r0_ren = 1'b1; r0_addr = 32'h300; r0_burstcount = 6'd3;
    half(); tick(); half(); check("t5_r0_cmd", amm_addr, 32'h300);
    tick(); r0_ren = 1'b0;
    r1_ren = 1'b1; r1_addr = 32'h400; r1_burstcount = 6'd2;
    half(); tick(); half(); check("t5_r1_cmd", amm_addr, 32'h400); check("t5_r1_ren", amm_ren, 1'b1);
    tick(); r1_ren = 1'b0;
    repeat (3) begin half(); tick(); end
    exp_q = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    while (exp_q.size() > 0) begin
      own = int'(exp_q.pop_front());
      amm_rvalid = 1'b1; amm_rdata = 64'hB0 + 64'(exp_q.size());
      half();
      check("t5_route_rv0", r0_rvalid, own == 0); check("t5_route_rv1", r1_rvalid, own == 1);
      check("t5_rdata1", r1_rdata, amm_rdata);
      tick(); amm_rvalid = 1'b0;
      half(); tick();
    end

    // Unexpected return data.
    amm_rvalid = 1'b1;
    half(); check("err_rv0", r0_rvalid, 1'b0); check("err_rv1", r1_rvalid, 1'b0);
    tick(); amm_rvalid = 1'b0;
    half(); check("err_set", err_rvalid, 1'b1);
    tick(); half(); check("err_sticky", err_rvalid, 1'b1);
    tick();

    // Read and write both high: read wins.
    r1_ren = 1'b1; r1_wen = 1'b1; r1_addr = 32'h500; r1_burstcount = 6'd1;
    half(); tick(); half();
    check("rw_ren", amm_ren, 1'b1); check("rw_wen", amm_wen, 1'b0); check("rw_w1", r1_wait, 1'b0);
    tick(); r1_ren = 1'b0; r1_wen = 1'b0;
    amm_rvalid = 1'b1;
    half(); check("rw_ret", r1_rvalid, 1'b1);
    tick(); amm_rvalid = 1'b0;

    // Reset in the middle of a write burst.
    r0_wen = 1'b1; r0_addr = 32'h600; r0_burstcount = 6'd4; r0_wdata = 64'hE0;
    half(); tick(); half(); check("rst_mid_wen", amm_wen, 1'b1);
    tick(); r0_wdata = 64'hE1;
    half(); tick();
    rst = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid_state", dbg_state, ST_IDLE);
    check("rst_mid_count", dbg_tag_count, 4'd0);
    r0_wen = 1'b0;
    tick(); rst = 1'b0;
    half(); tick();

    // Randomized traffic from both requesters against a controller model.
    for (int n = 0; n < 2; n++) begin
      act[n] = 1'b0; is_rd[n] = 1'b0; rbc[n] = '0; left[n] = 0; beat[n] = 0; seq[n] = 0;
      radr[n] = '0; acc[n] = 1'b0;
    end
    exp_q.delete();
    for (int c = 0; c < 4000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!act[n] && c < 2500 && $urandom_range(0, 2) == 0) begin
          act[n]   = 1'b1;
          is_rd[n] = 1'($urandom_range(0, 1));
          rbc[n]   = BW'($urandom_range(0, 4));
          left[n]  = (rbc[n] == 0) ? 1 : int'(rbc[n]);
          beat[n]  = 0;
          seq[n]++;
          radr[n]  = (32'(n) << 31) | (32'(seq[n]) << 4);
        end
      end
      drive_reqs();
      amm_wait   = ($urandom_range(0, 3) == 0);
      amm_rvalid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      amm_rdata  = {$urandom, $urandom};
      half();
      acc[0]  = (r0_ren || r0_wen) && !r0_wait;
      acc[1]  = (r1_ren || r1_wen) && !r1_wait;
      amm_acc = (amm_ren || amm_wen) && !amm_wait;
      check("rand_acc_match", 64'(int'(acc[0]) + int'(acc[1])), 64'(amm_acc));
      if (amm_acc) begin
        own = int'(amm_addr[AW-1]);
        check("rand_owner", acc[own], 1'b1);
        check("rand_addr", amm_addr, radr[own]);
        check("rand_bc", amm_burstcount, rbc[own]);
        check("rand_kind", amm_ren, is_rd[own]);
        if (!is_rd[own]) check("rand_wdata", amm_wdata, wdata_of(own, seq[own], beat[own]));
        else for (int b = 0; b < left[own]; b++) exp_q.push_back(1'(own));
      end
      if (amm_rvalid) begin
        own = int'(exp_q.pop_front());
        check("rand_rv0", r0_rvalid, own == 0);
        check("rand_rv1", r1_rvalid, own == 1);
        check("rand_rdata", r0_rdata, amm_rdata);
      end else begin
        check("rand_no_rv", {r0_rvalid, r1_rvalid}, 2'b00);
      end
      tick();
      for (int n = 0; n < 2; n++) begin
        if (acc[n]) begin
          if (is_rd[n]) act[n] = 1'b0;
          else begin
            beat[n]++;
            left[n]--;
            if (left[n] == 0) act[n] = 1'b0;
          end
        end
      end
      if (c >= 2500 && !act[0] && !act[1] && exp_q.size() == 0) break;
    end
    check("rand_drained", 64'({act[0], act[1]}) + 64'(exp_q.size()), 64'd0);
    check("rand_err_clear", err_rvalid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
